// File: rtl/icb_cmd_initiator.sv
// ICB initiator: turns single-word local requests into ICB command/response
// transactions, one outstanding at a time, with a response timeout.
`timescale 1ns/1ps
module icb_cmd_initiator #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          req_read,
  input  logic [DW-1:0] req_wdata,
  output logic          res_valid,
  output logic [DW-1:0] res_rdata,
  output logic          res_err,
  output logic          busy,
  output logic          o_icb_cmd_valid,
  input  logic          o_icb_cmd_ready,
  output logic [AW-1:0] o_icb_cmd_addr,
  output logic          o_icb_cmd_read,
  output logic [DW-1:0] o_icb_cmd_wdata,
  input  logic          o_icb_rsp_valid,
  output logic          o_icb_rsp_ready,
  input  logic [DW-1:0] o_icb_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT - 1) : '0;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt;
  logic          accept, complete, timeout_hit;

  assign req_ready       = (state == IDLE);
  assign busy            = (state != IDLE);
  assign o_icb_cmd_valid = (state == CMD);
  // Responses are always accepted; anything outside a live transaction is dropped.
  assign o_icb_rsp_ready = 1'b1;

  assign accept      = (state == IDLE) && req_valid;
  assign complete    = o_icb_rsp_valid &&
                       (((state == CMD) && o_icb_cmd_ready) || (state == RSP));
  // A completion in the timeout cycle takes priority over the error.
  assign timeout_hit = TO_EN && (state != IDLE) && (cnt == TO_LAST) && !complete;

  always_comb begin
    // NOTE: assign every always_comb output a default first so no path infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) state_nxt = CMD;
      CMD: begin
        if (complete || timeout_hit) state_nxt = IDLE;
        else if (o_icb_cmd_ready)    state_nxt = RSP;
      end
      RSP: if (complete || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_icb_cmd_addr  <= '0;
      o_icb_cmd_read  <= 1'b0;
      o_icb_cmd_wdata <= '0;
      cnt             <= '0;
    end else if (accept) begin
      o_icb_cmd_addr  <= req_addr;
      o_icb_cmd_read  <= req_read;
      o_icb_cmd_wdata <= req_wdata;
      cnt             <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_rdata <= '0;
    end else begin
      res_valid <= complete || timeout_hit;
      res_err   <= timeout_hit;
      res_rdata <= (complete && o_icb_cmd_read) ? o_icb_rsp_rdata : '0;
    end
  end

endmodule

// File: doc/icb_cmd_initiator.md
Name: icb_cmd_initiator

Overview:
- ICB initiator (master) that turns single-word local requests into ICB command/response transactions toward a register-mapped responder such as the robotic-arm ICB register block.
- One transaction outstanding at a time; cycle-accurate valid/ready handshaking on both ICB channels.
- Returns the read data, or a timeout error, to the local requester as a one-cycle result pulse.
- Sits between a local controller (sequencer/CPU-side bridge) and the ICB slave port of peripheral blocks.

Parameters:
- AW, 32, ICB address width.
- DW, 32, ICB data width.
- TW, 8, timeout counter width.
- TIMEOUT, 255, cycles allowed from entering CMD until the response handshake. 0 disables timeout. Must be less than 2^TW.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  local request valid.
- req_ready  out  1  local request accepted when req_valid && req_ready.
- req_addr  in  AW  request address.
- req_read  in  1  1 = read, 0 = write.
- req_wdata  in  DW  write data.
- res_valid  out  1  one-cycle result pulse; no backpressure.
- res_rdata  out  DW  read data; 0 for writes and for errors.
- res_err  out  1  1 = timeout, qualified by res_valid.
- busy  out  1  state != IDLE.
- o_icb_cmd_valid  out  1  command valid.
- o_icb_cmd_ready  in  1  command ready from responder.
- o_icb_cmd_addr  out  AW  command address.
- o_icb_cmd_read  out  1  command read flag.
- o_icb_cmd_wdata  out  DW  command write data.
- o_icb_rsp_valid  in  1  response valid from responder.
- o_icb_rsp_ready  out  1  response ready.
- o_icb_rsp_rdata  in  DW  response read data.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - All command outputs 0, res_valid = 0, res_rdata = 0, res_err = 0, busy = 0, timeout counter = 0.
  - Reset mid-transaction drops o_icb_cmd_valid immediately and discards the transaction; no result pulse is issued.
- FSM states: IDLE, CMD, RSP.
- IDLE:
  - req_ready = 1 (combinational from state).
  - On req_valid, register addr/read/wdata into the command outputs; go to CMD.
  - o_icb_cmd_valid = 1 from the next cycle.
  - o_icb_rsp_ready = 1; stray responses are accepted and discarded.
- CMD:
  - o_icb_cmd_valid = 1; addr/read/wdata held stable until the handshake.
  - o_icb_rsp_ready = 1.
  - On o_icb_cmd_ready = 1, the command handshake completes:
    - If o_icb_rsp_valid is also 1 in the same cycle, the response is taken (zero-latency responder) and the FSM goes to IDLE with a result.
    - Otherwise the FSM goes to RSP.
    - o_icb_cmd_valid deasserts in the next cycle in both cases.
  - o_icb_rsp_valid with o_icb_cmd_ready = 0 is a stray response and is discarded.
- RSP:
  - o_icb_cmd_valid = 0, o_icb_rsp_ready = 1.
  - On o_icb_rsp_valid, complete the transaction and go to IDLE.
- Result, registered, asserted the cycle after the completing handshake:
  - res_valid = 1 for exactly one cycle, res_err = 0.
  - res_rdata = o_icb_rsp_rdata for reads, 0 for writes.
- Timeout:
  - Counter clears on entry to CMD and increments on every cycle spent in CMD or RSP.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without completion, the FSM goes to IDLE, drops o_icb_cmd_valid, and issues res_valid = 1, res_err = 1, res_rdata = 0 the next cycle.
  - A completion in the same cycle as the timeout wins; it is reported as success.
- Latency:
  - Request accepted at cycle N; o_icb_cmd_valid is high at N+1.
  - With cmd_ready at N+1 and rsp_valid at N+2, res_valid is at N+3.
  - With a same-cycle response at N+1, res_valid is at N+2.
- Back-to-back: a new request may be accepted in the same cycle res_valid is high (FSM already in IDLE).
- busy = 1 in CMD and RSP.

Test Plan:
- Write: req addr=0x0, wdata=10, read=0 at N. Responder cmd_ready=1 at N+1, rsp_valid at N+2. Required: cmd_addr=0, cmd_wdata=10 at N+1; res_valid at N+3 with res_err=0, res_rdata=0.
- Read: req addr=0x3, read=1. Responder returns rdata=0xA5A5_0003 one cycle after the command handshake. Required: res_rdata=0xA5A5_0003, res_err=0; req_ready=0 until the FSM is back in IDLE.
- Command stall: cmd_ready held 0 for 4 cycles. Required: cmd_valid stays 1 and addr/read/wdata stay unchanged for all 4 cycles; handshake on cycle 5; exactly one result pulse.
- Same-cycle response: responder drives rsp_valid together with cmd_ready for a read returning 0x12. Required: res_valid exactly 1 cycle later, res_rdata=0x12; no entry to RSP.
- Timeout: TIMEOUT=8, cmd_ready=1, rsp_valid never asserted. Required: res_valid=1, res_err=1, res_rdata=0 on the 9th cycle after cmd_valid rises. A later stray rsp_valid in IDLE is discarded with no res_valid.
- Reset mid-RSP: assert rst while in RSP. Required: cmd_valid=0, busy=0, res_valid=0 immediately; after release, a new write request completes normally.
